// File: rtl/config_frame_pkg.sv
// Shared types and constants for the configuration frame loader.
// Ports: none (package only).
// Holds the FSM state encoding, header field positions and default session words.
package config_frame_pkg;

  typedef enum logic [1:0] {
    UNSYNCED = 2'd0,
    HEADER   = 2'd1,
    DATA     = 2'd2,
    SKIP     = 2'd3
  } cfg_state_t;

  // Header word layout: column in the top byte, frame mask in the low bits.
  localparam int COL_MSB = 31;
  localparam int COL_LSB = 24;

  localparam logic [31:0] SYNC_WORD_DEF  = 32'hFAB0_FAB1;
  localparam logic [7:0]  DESYNC_COL_DEF = 8'hFF;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Purpose: decode column + frame mask into the per-column one-hot FrameStrobe bus.
// Latency: 1 cycle from fire to strobe; the strobe is a single-cycle pulse.
// Backpressure: none; fire is a qualified event and is never stalled.
// Ports: CLK/resetn (sync, active low), fire, col, mask in; strobe out.
module frame_strobe_decoder #(
  parameter int NUM_COLUMNS = 16,
  parameter int MAX_FRAMES  = 20,
  parameter int COL_W       = 4
) (
  input  logic                              CLK,
  input  logic                              resetn,
  input  logic                              fire,
  input  logic [COL_W-1:0]                  col,
  input  logic [MAX_FRAMES-1:0]             mask,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0] strobe
);

  logic [NUM_COLUMNS*MAX_FRAMES-1:0] dec;

  always_comb begin
    dec = '0;
    for (int c = 0; c < NUM_COLUMNS; c++) begin
      if (fire && (col == COL_W'(c))) begin
        dec[c*MAX_FRAMES +: MAX_FRAMES] = mask;
      end
    end
  end

  // fire is only ever high for one cycle, so reloading every cycle yields a pulse.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      strobe <= '0;
    end else begin
      strobe <= dec;
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Purpose: turn the 32-bit bitstream word stream into FrameData plus FrameStrobe pulses.
// Latency: FrameData updates on each accepted data word; strobe 1 cycle after last word.
// Backpressure: none; one word per cycle sustained, idle cycles hold all state.
// Ports: CLK, resetn (sync, active low), WriteData/WriteStrobe in;
//        FrameData, FrameStrobe, ConfigActive, ConfigError (sticky), ConfigDone (pulse) out.
module config_frame_loader
  import config_frame_pkg::*;
#(
  parameter int          NUM_ROWS    = 4,
  parameter int          NUM_COLUMNS = 16,
  parameter int          MAX_FRAMES  = 20,
  parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter logic [7:0]  DESYNC_COL  = DESYNC_COL_DEF
) (
  input  logic                              CLK,
  input  logic                              resetn,
  input  logic [31:0]                       WriteData,
  input  logic                              WriteStrobe,
  output logic [NUM_ROWS*32-1:0]            FrameData,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0] FrameStrobe,
  output logic                              ConfigActive,
  output logic                              ConfigError,
  output logic                              ConfigDone
);

  localparam int FW    = NUM_ROWS * 32;
  localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int CNT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROWS - 1);

  cfg_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [COL_W-1:0]        col_q;
  logic [MAX_FRAMES-1:0]   mask_q;
  logic [FW-1:0]           frame_q;
  logic                    active_q, active_d;
  logic                    error_q;
  logic                    done_q, done_d;
  logic                    hdr_load, shift_en, fire, err_set, err_clr;

  logic [7:0]              hdr_col;
  logic [MAX_FRAMES-1:0]   hdr_mask;

  assign hdr_col  = WriteData[COL_MSB:COL_LSB];
  assign hdr_mask = WriteData[MAX_FRAMES-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    hdr_load = 1'b0;
    shift_en = 1'b0;
    fire     = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    if (WriteStrobe) begin
      unique case (state_q)
        UNSYNCED: begin
          if (WriteData == SYNC_WORD) begin
            state_d  = HEADER;
            active_d = 1'b1;
            err_clr  = 1'b1;
          end
        end
        HEADER: begin
          // A repeated sync word is tolerated between frames.
          if (WriteData == SYNC_WORD) begin
            state_d = HEADER;
          end else if (hdr_col == DESYNC_COL) begin
            state_d  = UNSYNCED;
            active_d = 1'b0;
            done_d   = 1'b1;
          end else if (32'(hdr_col) < NUM_COLUMNS) begin
            state_d  = DATA;
            cnt_d    = '0;
            hdr_load = 1'b1;
          end else begin
            state_d = SKIP;
            cnt_d   = '0;
            err_set = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (cnt_q == LAST_CNT) begin
            fire    = 1'b1;
            cnt_d   = '0;
            state_d = HEADER;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SKIP: begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = HEADER;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = UNSYNCED;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q  <= UNSYNCED;
      cnt_q    <= '0;
      col_q    <= '0;
      mask_q   <= '0;
      frame_q  <= '0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
      if (hdr_load) begin
        col_q  <= COL_W'(hdr_col);
        mask_q <= hdr_mask;
      end
      // Shift toward the top row: first word of a frame ends up in the top row.
      if (shift_en) begin
        frame_q <= (frame_q << 32) | FW'(WriteData);
      end
      if (err_clr) begin
        error_q <= 1'b0;
      end else if (err_set) begin
        error_q <= 1'b1;
      end
    end
  end

  frame_strobe_decoder #(
    .NUM_COLUMNS (NUM_COLUMNS),
    .MAX_FRAMES  (MAX_FRAMES),
    .COL_W       (COL_W)
  ) u_strobe (
    .CLK    (CLK),
    .resetn (resetn),
    .fire   (fire),
    .col    (col_q),
    .mask   (mask_q),
    .strobe (FrameStrobe)
  );

  assign FrameData    = frame_q;
  assign ConfigActive = active_q;
  assign ConfigError  = error_q;
  assign ConfigDone   = done_q;

endmodule

// File: tb/tb_config_frame_loader.sv
module tb_config_frame_loader;

  localparam int          NR   = 4;
  localparam int          NC   = 16;
  localparam int          MF   = 20;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic              CLK = 1'b0;
  logic              resetn;
  logic [31:0]       WriteData;
  logic              WriteStrobe;
  logic [NR*32-1:0]  FrameData;
  logic [NC*MF-1:0]  FrameStrobe;
  logic              ConfigActive, ConfigError, ConfigDone;

  config_frame_loader dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .WriteData    (WriteData),
    .WriteStrobe  (WriteStrobe),
    .FrameData    (FrameData),
    .FrameStrobe  (FrameStrobe),
    .ConfigActive (ConfigActive),
    .ConfigError  (ConfigError),
    .ConfigDone   (ConfigDone)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NC*MF-1:0] strb;
    logic [NR*32-1:0] data;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  int               cyc = 0;
  int               n_vec = 0;
  int               n_err = 0;
  logic [NR*32-1:0] last_data = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [NC*MF-1:0] got, input logic [NC*MF-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every non-zero strobe must match the oldest pending frame, on the right cycle.
  always @(negedge CLK) begin
    if (FrameStrobe !== '0) begin
      if (sb.size() == 0) begin
        check("spurious_strobe", FrameStrobe, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_bits", FrameStrobe, e.strb);
        check("strobe_data", FrameData, e.data);
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic put(input logic [31:0] w);
    WriteData   = w;
    WriteStrobe = 1'b1;
    @(posedge CLK);
    #1;
    WriteStrobe = 1'b0;
    WriteData   = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Header, then four data words; valid=1 means the loader is expected to take the frame.
  task automatic frame(input logic [7:0] col, input logic [MF-1:0] mask,
                       input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3,
                       input bit gaps, input bit valid);
    logic [31:0]      w [4];
    logic [NC*MF-1:0] s;
    exp_t             e;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    put({col, 4'($urandom), mask});
    for (int i = 0; i < 4; i++) begin
      if (gaps && i > 0) idle($urandom_range(0, 3));
      put(w[i]);
    end
    if (valid) begin
      last_data = {w0, w1, w2, w3};
      if (mask != '0) begin
        s = '0;
        s[int'(col)*MF +: MF] = mask;
        e.strb = s;
        e.data = last_data;
        e.cyc  = cyc;
        sb.push_back(e);
      end
    end
    check("frame_data", FrameData, last_data);
  endtask

  initial begin
    resetn      = 1'b0;
    WriteStrobe = 1'b0;
    WriteData   = '0;
    idle(2);
    check("rst_data", FrameData, '0);
    check("rst_strobe", FrameStrobe, '0);
    check("rst_active", ConfigActive, 0);
    check("rst_error", ConfigError, 0);
    check("rst_done", ConfigDone, 0);
    resetn = 1'b1;
    idle(1);

    // Unsynced: non-sync words and even a well-formed header do nothing.
    put(32'h1234_5678);
    put(32'h0300_0004);
    idle(2);
    check("unsync_active", ConfigActive, 0);
    check("unsync_data", FrameData, '0);
    put(SYNC);
    check("sync_active", ConfigActive, 1);
    check("sync_error", ConfigError, 0);

    // Basic frame: column 3, frame 2 -> strobe bit 62.
    frame(8'h03, 20'h00004, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004, 0, 1);
    idle(2);
    // Sync word in HEADER is ignored without error.
    put(SYNC);
    check("hdr_sync_err", ConfigError, 0);
    check("hdr_sync_act", ConfigActive, 1);

    // Column 15, empty mask: data loads, no strobe.
    frame(8'h0F, 20'h00000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 0, 1);
    check("mask0_error", ConfigError, 0);

    // Back-to-back frames, one carrying a sync-valued data word.
    frame(8'h00, 20'h00001, SYNC, 32'h0BAD_F00D, 32'h5555_AAAA, 32'h0000_0001, 0, 1);
    frame(8'h0F, 20'hFFFFF, 32'hDEAD_BEEF, 32'hCAFE_F00D, SYNC, 32'h8000_0000, 0, 1);

    // Same as the first frame but with idle gaps between words.
    frame(8'h03, 20'h00004, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004, 1, 1);
    for (int k = 0; k < 3; k++) begin
      frame(8'(k * 5), 20'($urandom), $urandom, $urandom, $urandom, $urandom, 1, 1);
    end

    // Bad column: error set, four words swallowed, later frames still work.
    put(32'h2000_0001);
    check("bad_col_error", ConfigError, 1);
    for (int i = 0; i < 4; i++) put($urandom);
    check("skip_data", FrameData, last_data);
    frame(8'h05, 20'h80001, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404, 0, 1);
    check("error_sticky", ConfigError, 1);

    // Desync: done pulse, inactive, later headers ignored.
    put(32'hFF00_0000);
    check("desync_done", ConfigDone, 1);
    check("desync_active", ConfigActive, 0);
    check("desync_error", ConfigError, 1);
    idle(1);
    check("done_pulse_end", ConfigDone, 0);
    frame(8'h02, 20'h00010, 32'h9999_9999, 32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 0, 0);
    check("post_desync_act", ConfigActive, 0);
    put(SYNC);
    check("resync_error", ConfigError, 0);
    check("resync_active", ConfigActive, 1);

    // Reset in the middle of a frame discards it.
    put(32'h0100_0003);
    put(32'hEEEE_0001);
    put(32'hEEEE_0002);
    resetn = 1'b0;
    idle(1);
    check("midrst_data", FrameData, '0);
    check("midrst_active", ConfigActive, 0);
    check("midrst_strobe", FrameStrobe, '0);
    resetn = 1'b1;
    last_data = '0;
    idle(2);
    put(SYNC);
    frame(8'h01, 20'h00003, 32'h1357_9BDF, 32'h2468_ACE0, 32'hF0F0_0F0F, 32'h0F0F_F0F0, 0, 1);

    // Let the final strobe drain, bounded.
    for (int t = 0; t < 20 && sb.size() != 0; t++) idle(1);
    idle(2);
    check("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
